// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding.
// It also detects load-use hazards and handles hold and flush.
module id_ex_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int ALUCTRL_WIDTH  = 3,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      valid_i,
  input  logic [ALUCTRL_WIDTH-1:0]  ALUCtrl_i,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_addr_i,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_addr_i,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr_i,
  input  logic                      rs1_used_i,
  input  logic                      rs2_used_i,
  input  logic [DATA_WIDTH-1:0]     rs1_data_i,
  input  logic [DATA_WIDTH-1:0]     rs2_data_i,
  input  logic [DATA_WIDTH-1:0]     imm_i,
  input  logic                      ALUsrc_i,
  input  logic                      regwrite_i,
  input  logic                      memread_i,
  input  logic                      memwrite_i,
  input  logic                      exmem_regwrite,
  input  logic                      memwb_regwrite,
  input  logic [REG_ADDR_WIDTH-1:0] exmem_rd,
  input  logic [REG_ADDR_WIDTH-1:0] memwb_rd,
  input  logic [DATA_WIDTH-1:0]     exmem_result,
  input  logic [DATA_WIDTH-1:0]     memwb_result,
  input  logic                      stall_i,
  input  logic                      flush_i,
  output logic [ALUCTRL_WIDTH-1:0]  ALUCtrl,
  output logic [DATA_WIDTH-1:0]     ALUop1,
  output logic [DATA_WIDTH-1:0]     ALUop2,
  output logic [DATA_WIDTH-1:0]     store_data_o,
  output logic [REG_ADDR_WIDTH-1:0] rd_o,
  output logic                      valid_o,
  output logic                      regwrite_o,
  output logic                      memread_o,
  output logic                      memwrite_o,
  output logic                      load_use_stall_o
);

  typedef struct packed {
    logic                      valid;
    logic [ALUCTRL_WIDTH-1:0]  aluctrl;
    logic [REG_ADDR_WIDTH-1:0] rs1_addr;
    logic [REG_ADDR_WIDTH-1:0] rs2_addr;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0]     rs1_data;
    logic [DATA_WIDTH-1:0]     rs2_data;
    logic [DATA_WIDTH-1:0]     imm;
    logic                      alusrc;
    logic                      regwrite;
    logic                      memread;
    logic                      memwrite;
  } slot_t;

  slot_t slot_q, slot_d;
  logic [DATA_WIDTH-1:0] fwd1, fwd2;
  logic                  rs1_hit, rs2_hit;

  // EX/MEM beats MEM/WB; x0 always reads the register file value.
  function automatic logic [DATA_WIDTH-1:0] forward(
    input logic [REG_ADDR_WIDTH-1:0] addr,
    input logic [DATA_WIDTH-1:0]     data
  );
    logic [DATA_WIDTH-1:0] val;
    val = data;
    if (addr != '0) begin
      if (exmem_regwrite && exmem_rd == addr)
        val = exmem_result;
      else if (memwb_regwrite && memwb_rd == addr)
        val = memwb_result;
    end
    return val;
  endfunction

  always_comb begin
    fwd1 = forward(slot_q.rs1_addr, slot_q.rs1_data);
    fwd2 = forward(slot_q.rs2_addr, slot_q.rs2_data);
  end

  always_comb begin
    rs1_hit = rs1_used_i && (rs1_addr_i == slot_q.rd);
    rs2_hit = rs2_used_i && (rs2_addr_i == slot_q.rd);
    load_use_stall_o = slot_q.valid && slot_q.memread && (slot_q.rd != '0) &&
                       valid_i && (rs1_hit || rs2_hit) && !flush_i && !stall_i;
  end

  always_comb begin
    slot_d = slot_q;
    if (flush_i) begin
      slot_d = '0;
    end else if (stall_i) begin
      // Capture forwarded values so a producer retiring during the hold is kept.
      slot_d.rs1_data = fwd1;
      slot_d.rs2_data = fwd2;
    end else if (load_use_stall_o) begin
      slot_d = '0;
    end else begin
      slot_d.valid    = valid_i;
      slot_d.aluctrl  = ALUCtrl_i;
      slot_d.rs1_addr = rs1_addr_i;
      slot_d.rs2_addr = rs2_addr_i;
      slot_d.rd       = rd_addr_i;
      slot_d.rs1_data = rs1_data_i;
      slot_d.rs2_data = rs2_data_i;
      slot_d.imm      = imm_i;
      slot_d.alusrc   = ALUsrc_i;
      slot_d.regwrite = regwrite_i;
      slot_d.memread  = memread_i;
      slot_d.memwrite = memwrite_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) slot_q <= '0;
    else     slot_q <= slot_d;
  end

  always_comb begin
    ALUCtrl      = slot_q.aluctrl;
    ALUop1       = fwd1;
    ALUop2       = slot_q.alusrc ? slot_q.imm : fwd2;
    store_data_o = fwd2;
    rd_o         = slot_q.rd;
    valid_o      = slot_q.valid;
    regwrite_o   = slot_q.valid && slot_q.regwrite;
    memread_o    = slot_q.valid && slot_q.memread;
    memwrite_o   = slot_q.valid && slot_q.memwrite;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline stage that sits directly upstream of the ALU. It registers decoded operands, the immediate, ALUCtrl and the downstream control bits. It resolves data hazards by forwarding from the EX/MEM and MEM/WB stages, detects load-use hazards and inserts a bubble for them. It also supports an external hold and flush, and drives ALUop1, ALUop2 and ALUCtrl to the ALU every cycle.

## Interface
- DATA_WIDTH, 32, operand/result width
- ALUCTRL_WIDTH, 3, ALU opcode width
- REG_ADDR_WIDTH, 5, register index width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- valid_i  in  1  decode slot holds a real instruction
- ALUCtrl_i  in  ALUCTRL_WIDTH  decoded ALU opcode
- rs1_addr_i, rs2_addr_i, rd_addr_i  in  REG_ADDR_WIDTH  source/destination indices
- rs1_used_i, rs2_used_i  in  1  instruction reads rs1/rs2
- rs1_data_i, rs2_data_i  in  DATA_WIDTH  register file read data
- imm_i  in  DATA_WIDTH  sign-extended immediate
- ALUsrc_i  in  1  1 = ALUop2 takes immediate
- regwrite_i, memread_i, memwrite_i  in  1  downstream control
- exmem_regwrite, memwb_regwrite  in  1  later stage will write rd
- exmem_rd, memwb_rd  in  REG_ADDR_WIDTH  later-stage destinations
- exmem_result, memwb_result  in  DATA_WIDTH  later-stage values
- stall_i  in  1  hold this stage
- flush_i  in  1  kill the instruction entering this stage
- ALUCtrl  out  ALUCTRL_WIDTH  to ALU
- ALUop1, ALUop2  out  DATA_WIDTH  to ALU
- store_data_o  out  DATA_WIDTH  forwarded rs2 for stores
- rd_o  out  REG_ADDR_WIDTH; valid_o, regwrite_o, memread_o, memwrite_o  out  1  registered control
- load_use_stall_o  out  1  upstream must hold decode/fetch this cycle

## Operation
- State: one register slot holding every *_i field (the "q" copies).
- Next-state priority, highest first:
  1. rst: clears all q fields to 0.
  2. flush_i: loads a bubble (valid, regwrite, memread, memwrite = 0; other fields don't-care, driven 0).
  3. stall_i: holds the slot. rs1_data_q and rs2_data_q are refreshed with the current forwarded values, so a dependency that retires during the hold is not lost.
  4. load_use_stall_o: loads a bubble. The upstream holds, so the same instruction is presented again next cycle.
  5. Otherwise: loads the *_i fields.
- Forwarding is combinational on the q fields and applies per operand.
  - If exmem_regwrite, exmem_rd == rs_addr_q and rs_addr_q != 0, the operand is exmem_result.
  - Else if memwb_regwrite, memwb_rd == rs_addr_q and rs_addr_q != 0, the operand is memwb_result.
  - Else the operand is rs_data_q.
  - EX/MEM always beats MEM/WB.
  - Register index 0 is never forwarded; its operand value is rs_data_q as read.
- ALUop1 = fwd1. ALUop2 = ALUsrc_q ? imm_q : fwd2. store_data_o = fwd2.
- Outputs are qualified by valid_o only for control: regwrite_o, memread_o and memwrite_o are forced 0 when valid_o = 0.
- load_use_stall_o = valid_o & memread_o & (rd_o != 0) & valid_i & ((rs1_used_i & rs1_addr_i == rd_o) | (rs2_used_i & rs2_addr_i == rd_o)). It is combinational and is masked to 0 when flush_i or stall_i is asserted.

## Timing
- Latency: one cycle, from decode inputs sampled at edge N to outputs valid after edge N.
- Forwarding path is combinational: a change on exmem_*/memwb_* is visible on ALUop1/ALUop2 in the same cycle.
- A load-use hazard costs exactly one bubble cycle.
- Reset is asynchronous: outputs go to 0 immediately on rst, independent of clk. Release takes effect at the next edge.
- Reset asserted mid-stall or mid-bubble discards the slot. No hazard state survives reset.
- Simultaneous events:
  - flush_i with stall_i: flush wins, and the slot becomes a bubble.
  - stall_i with a load-use condition: hold wins, and load_use_stall_o stays 0.
- Reset values: ALUCtrl, ALUop1, ALUop2, store_data_o and rd_o are 0; valid_o, regwrite_o, memread_o, memwrite_o and load_use_stall_o are 0.

## Test plan
- Reset: rst=1 mid-cycle gives all outputs 0 asynchronously. After release, valid_i=1, ALUCtrl_i=3'b001, rs1_data_i=7, rs2_data_i=3 and ALUsrc_i=0 give ALUCtrl=001, ALUop1=7, ALUop2=3 after one edge.
- Forward priority: latched rs1=5. exmem (wr=1, rd=5, result=0xAA) and memwb (wr=1, rd=5, result=0xBB) give ALUop1=0xAA. Dropping exmem_regwrite gives ALUop1=0xBB.
- x0 and immediate: rs2=0 with exmem_rd=0, exmem_regwrite=1, result=0x55 gives store_data_o = rs2_data_q, not 0x55. ALUsrc=1 with imm=-4 gives ALUop2=0xFFFFFFFC.
- Load-use: latched load (memread=1, rd=8) and decode with rs1_used=1, rs1_addr=8 give load_use_stall_o=1 and a bubble after the edge (valid_o=0, regwrite_o=0). The re-presented instruction then latches with load_use_stall_o=0.
- Stall refresh: latched rs1=9 with memwb (rd=9, result=0x1234), then stall_i=1 for 2 cycles while memwb changes to rd=3. ALUop1 stays 0x1234 throughout and after release.
- Flush vs stall: flush_i=1 and stall_i=1 on the same edge give valid_o=0, memwrite_o=0 and load_use_stall_o=0.
